// File: rtl/matmul_controller_if.sv
// Control bundle between the 3x3 matmul sequencer and its datapath.
// The master modport is the controller; the slave modport is the datapath
// and display logic, which drive the index/done flags and STEP back.
interface matmul_controller_if;
   // Datapath -> controller
   logic START;
   logic i_notEQ3;
   logic j_notEQ3;
   logic k_notEQ3;
   logic Done_Flag;
   logic STEP;
   // Controller -> datapath
   logic sel_i;
   logic sel_j;
   logic sel_k;
   logic sel_sum;
   logic ld_i;
   logic ld_j;
   logic ld_k;
   logic ld_sum;
   logic ld_out;
   logic Count_En;
   logic Show_DATA;
   logic NEW_OUTPUT;
   logic busy;
   logic done;

   modport master (
      input  START, i_notEQ3, j_notEQ3, k_notEQ3, Done_Flag, STEP,
      output sel_i, sel_j, sel_k, sel_sum,
      output ld_i, ld_j, ld_k, ld_sum, ld_out,
      output Count_En, Show_DATA, NEW_OUTPUT, busy, done
   );

   modport slave (
      output START, i_notEQ3, j_notEQ3, k_notEQ3, Done_Flag, STEP,
      input  sel_i, sel_j, sel_k, sel_sum,
      input  ld_i, ld_j, ld_k, ld_sum, ld_out,
      input  Count_En, Show_DATA, NEW_OUTPUT, busy, done
   );
endinterface

// File: rtl/matmul_controller.sv
// Moore sequencer for a 3x3 matrix multiply: walks i/j/k loops, accumulates
// each dot product, stores it into C, then hands off to the result display.
// Optional macro MMC_STEP_EN: display NEW_OUTPUT pulses follow rising edges
// of STEP instead of the HOLD_CYCLES hold counter.
// All outputs are decoded from the state register (plus the hold counter or
// STEP edge for NEW_OUTPUT), so reset forces every output low immediately.
module matmul_controller #(
   parameter int unsigned HOLD_CYCLES = 1  // 1..255
) (
   input  logic                       CLK,
   input  logic                       RST,         // async, active-low
   matmul_controller_if.master        bus,
   output logic [3:0]                 dbg_state_o
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_INIT_I = 4'd1,
      S_INIT_J = 4'd2,
      S_CLR    = 4'd3,
      S_RD     = 4'd4,
      S_ACC    = 4'd5,
      S_STORE  = 4'd6,
      S_INC_J  = 4'd7,
      S_CHK_J  = 4'd8,
      S_INC_I  = 4'd9,
      S_CHK_I  = 4'd10,
      S_SHOW   = 4'd11,
      S_DUMP   = 4'd12,
      S_DONE   = 4'd13
   } state_t;

   state_t state_q, state_d;

   assign dbg_state_o = state_q;

   // State register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic and state-decoded outputs
   always_comb begin
      state_d       = state_q;
      bus.sel_i     = 1'b0;
      bus.sel_j     = 1'b0;
      bus.sel_k     = 1'b0;
      bus.sel_sum   = 1'b0;
      bus.ld_i      = 1'b0;
      bus.ld_j      = 1'b0;
      bus.ld_k      = 1'b0;
      bus.ld_sum    = 1'b0;
      bus.ld_out    = 1'b0;
      bus.Count_En  = 1'b0;
      bus.Show_DATA = 1'b0;
      bus.done      = 1'b0;
      bus.busy      = 1'b1;
      case (state_q)
         S_IDLE: begin
            bus.busy = 1'b0;
            if (bus.START) state_d = S_INIT_I;
         end
         S_INIT_I: begin
            bus.ld_i = 1'b1;
            state_d  = S_INIT_J;
         end
         S_INIT_J: begin
            bus.ld_j = 1'b1;
            state_d  = S_CLR;
         end
         S_CLR: begin
            bus.ld_k   = 1'b1;
            bus.ld_sum = 1'b1;
            state_d    = S_RD;
         end
         // One idle cycle lets the synchronous ROM present A[i][k] and B[k][j]
         S_RD: begin
            state_d = bus.k_notEQ3 ? S_ACC : S_STORE;
         end
         S_ACC: begin
            bus.ld_sum  = 1'b1;
            bus.sel_sum = 1'b1;
            bus.ld_k    = 1'b1;
            bus.sel_k   = 1'b1;
            state_d     = S_RD;
         end
         S_STORE: begin
            bus.ld_out = 1'b1;
            state_d    = S_INC_J;
         end
         S_INC_J: begin
            bus.ld_j  = 1'b1;
            bus.sel_j = 1'b1;
            state_d   = S_CHK_J;
         end
         // Flag is checked one cycle after the increment so it reflects the new j
         S_CHK_J: begin
            state_d = bus.j_notEQ3 ? S_CLR : S_INC_I;
         end
         S_INC_I: begin
            bus.ld_i  = 1'b1;
            bus.sel_i = 1'b1;
            state_d   = S_CHK_I;
         end
         S_CHK_I: begin
            state_d = bus.i_notEQ3 ? S_INIT_J : S_SHOW;
         end
         S_SHOW: begin
            bus.Show_DATA = 1'b1;
            bus.Count_En  = 1'b1;
            state_d       = S_DUMP;
         end
         S_DUMP: begin
            bus.Count_En = 1'b1;
            if (bus.Done_Flag) state_d = S_DONE;
         end
         S_DONE: begin
            bus.done = 1'b1;
            state_d  = S_IDLE;
         end
         default: begin
            bus.busy = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

`ifdef MMC_STEP_EN
   logic       step_q;
   logic [7:0] unused_hold_cycles;

   assign unused_hold_cycles = 8'(HOLD_CYCLES);

   // Previous STEP value for rising-edge detection
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) step_q <= 1'b0;
      else      step_q <= bus.STEP;
   end

   // One display pulse per STEP rising edge while dumping
   always_comb begin
      bus.NEW_OUTPUT = (state_q == S_DUMP) && bus.STEP && !step_q;
   end
`else
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   logic [7:0] hold_q, hold_d;
   logic       unused_step;

   assign unused_step = bus.STEP;

   // Hold counter register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) hold_q <= 8'd0;
      else      hold_q <= hold_d;
   end

   // Counter sits at zero outside DUMP so the first DUMP cycle always pulses
   always_comb begin
      hold_d = 8'd0;
      if (state_q == S_DUMP) begin
         hold_d = (hold_q == HOLD_LAST) ? 8'd0 : hold_q + 8'd1;
      end
   end

   // Pulse on DUMP entry and every HOLD_CYCLES cycles after
   always_comb begin
      bus.NEW_OUTPUT = (state_q == S_DUMP) && (hold_q == 8'd0);
   end
`endif

endmodule

// File: tb/tb_matmul_controller.sv
// Bench for matmul_controller: models the index/display datapath around the
// controller, issues randomized runs, and scores event timing against cycle
// numbers derived from the loop structure (11 cycles per element, +3 per row).
`timescale 1ns/1ps
module tb_matmul_controller;

   localparam int H     = 3;
   localparam int T_RUN = 114 + 8*H;   // START cycle to next START-sampling IDLE

   // ---------------- clock / reset ----------------
   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] dbg_state;
   int         cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   matmul_controller_if bus();

   matmul_controller #(.HOLD_CYCLES(H)) dut (
      .CLK        (clk),
      .RST        (rst_n),
      .bus        (bus),
      .dbg_state_o(dbg_state)
   );

   // ---------------- datapath environment ----------------
   logic [1:0] i_r = 2'd0, j_r = 2'd0, k_r = 2'd0;
   logic [3:0] disp_cnt = 4'd0;
   logic       force_done = 1'b0;
   logic       step_prev = 1'b0;

   always @(posedge clk) begin
      if (bus.ld_i) i_r <= bus.sel_i ? i_r + 2'd1 : 2'd0;
      if (bus.ld_j) j_r <= bus.sel_j ? j_r + 2'd1 : 2'd0;
      if (bus.ld_k) k_r <= bus.sel_k ? k_r + 2'd1 : 2'd0;
      if (bus.Show_DATA) disp_cnt <= 4'd0;
      else if (bus.NEW_OUTPUT && disp_cnt != 4'd9) disp_cnt <= disp_cnt + 4'd1;
      step_prev <= bus.STEP;
   end

   assign bus.i_notEQ3  = (i_r != 2'd3);
   assign bus.j_notEQ3  = (j_r != 2'd3);
   assign bus.k_notEQ3  = (k_r != 2'd3);
   assign bus.Done_Flag = force_done || (disp_cnt == 4'd9);

`ifdef MMC_STEP_EN
   initial begin
      bus.STEP = 1'b0;
      forever begin
         repeat ($urandom_range(2, 6)) @(posedge clk);
         #1 bus.STEP = 1'b1;
         repeat ($urandom_range(1, 2)) @(posedge clk);
         #1 bus.STEP = 1'b0;
      end
   end
`else
   initial bus.STEP = 1'b0;
`endif

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_err    = 0;
   int exp_ld_q[$];
   int exp_show_q[$];
   int exp_nout_q[$];
   int exp_done_q[$];
   int busy_lo_q[$];
   int busy_hi_q[$];   // -1 = end not yet known
   int run_nout = 0;

   function automatic void check(string name, int act, int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [13:0] outs();
      return {bus.sel_i, bus.sel_j, bus.sel_k, bus.sel_sum,
              bus.ld_i, bus.ld_j, bus.ld_k, bus.ld_sum, bus.ld_out,
              bus.Count_En, bus.Show_DATA, bus.NEW_OUTPUT, bus.busy, bus.done};
   endfunction

   // Reference: run whose START is sampled in IDLE at cycle t0.
   // Element e (row e/3) is stored 11 cycles after the previous one, plus
   // 3 extra cycles at every row boundary; SHOW follows 5 cycles after the
   // last store; DUMP pulses every H cycles until the display has 9.
   function automatic void push_run(int t0, bit fd);
`ifndef MMC_STEP_EN
      int last;
`endif
      for (int e = 0; e < 9; e++) exp_ld_q.push_back(t0 + 11 + 11*e + 3*(e/3));
      exp_show_q.push_back(t0 + 110);
      busy_lo_q.push_back(t0 + 1);
`ifdef MMC_STEP_EN
      if (fd) begin
         exp_done_q.push_back(t0 + 112);
         busy_hi_q.push_back(t0 + 112);
      end else begin
         busy_hi_q.push_back(-1);
      end
`else
      if (fd) begin
         exp_nout_q.push_back(t0 + 111);
         last = t0 + 112;
      end else begin
         for (int n = 0; n < 9; n++) exp_nout_q.push_back(t0 + 111 + H*n);
         last = t0 + 113 + 8*H;
      end
      exp_done_q.push_back(last);
      busy_hi_q.push_back(last);
`endif
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (busy_hi_q.size() != 0 && busy_hi_q[0] >= 0 && cyc > busy_hi_q[0]) begin
            void'(busy_lo_q.pop_front());
            void'(busy_hi_q.pop_front());
         end
         check("busy", int'(bus.busy),
               int'(busy_lo_q.size() != 0 && cyc >= busy_lo_q[0] &&
                    (busy_hi_q[0] < 0 || cyc <= busy_hi_q[0])));

         if (bus.ld_out) begin
            if (exp_ld_q.size() != 0) check("ld_out cycle", cyc, exp_ld_q.pop_front());
            else                      check("ld_out unexpected", cyc, -1);
         end else if (exp_ld_q.size() != 0 && exp_ld_q[0] <= cyc) begin
            check("ld_out missing", -1, exp_ld_q.pop_front());
         end

         if (bus.Show_DATA) begin
            run_nout = 0;
            if (exp_show_q.size() != 0) check("show cycle", cyc, exp_show_q.pop_front());
            else                        check("show unexpected", cyc, -1);
         end else if (exp_show_q.size() != 0 && exp_show_q[0] <= cyc) begin
            check("show missing", -1, exp_show_q.pop_front());
         end

`ifdef MMC_STEP_EN
         if (bus.NEW_OUTPUT) begin
            check("new_output on step edge", int'({bus.STEP, step_prev}), 2);
            run_nout++;
            if (run_nout == 9 && !force_done && busy_hi_q.size() != 0) begin
               exp_done_q.push_back(cyc + 2);
               busy_hi_q[0] = cyc + 2;
            end
         end
`else
         if (bus.NEW_OUTPUT) begin
            if (exp_nout_q.size() != 0) check("new_output cycle", cyc, exp_nout_q.pop_front());
            else                        check("new_output unexpected", cyc, -1);
         end else if (exp_nout_q.size() != 0 && exp_nout_q[0] <= cyc) begin
            check("new_output missing", -1, exp_nout_q.pop_front());
         end
`endif

         if (bus.done) begin
            if (exp_done_q.size() != 0) check("done cycle", cyc, exp_done_q.pop_front());
            else                        check("done unexpected", cyc, -1);
         end else if (exp_done_q.size() != 0 && exp_done_q[0] <= cyc) begin
            check("done missing", -1, exp_done_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((busy_lo_q.size() != 0 || exp_ld_q.size() != 0 || exp_show_q.size() != 0 ||
              exp_nout_q.size() != 0 || exp_done_q.size() != 0) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (n >= 3000) check("drain timeout", n, 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic flush_queues();
      exp_ld_q.delete();
      exp_show_q.delete();
      exp_nout_q.delete();
      exp_done_q.delete();
      busy_lo_q.delete();
      busy_hi_q.delete();
   endtask

   // One START pulse, then spurious START pulses from cycle 50 of the run on
   task automatic run_one(input bit fd, input int n_spur);
      int t0;
      int o;
      force_done = fd;
      bus.START = 1'b1;
      t0 = cyc;
      push_run(t0, fd);
      @(posedge clk);
      #1 bus.START = 1'b0;
      o = t0 + 50;
      for (int s = 0; s < n_spur; s++) begin
         wait_to(o);
         bus.START = 1'b1;
         @(posedge clk);
         #1 bus.START = 1'b0;
         o = o + $urandom_range(3, 25);
      end
      wait_drain();
      force_done = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int t0;
      bus.START = 1'b0;
      #1 check("outputs in reset", int'(outs()), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1 check("outputs idle after reset", int'(outs()), 0);

      // Basic run with a START pulse at cycle 50 of the run
      run_one(1'b0, 1);

      // Randomized runs, some with Done_Flag already high on DUMP entry
      for (int r = 0; r < 3; r++) begin
         bit fd;
         repeat ($urandom_range(1, 6)) @(posedge clk);
         #1;
         fd = ($urandom_range(0, 2) == 0);
         run_one(fd, fd ? 1 : $urandom_range(1, 3));
      end

      // Reset during an ACC of the second row, then a clean restart
      repeat (3) @(posedge clk);
      #1 bus.START = 1'b1;
      t0 = cyc;
      push_run(t0, 1'b0);
      @(posedge clk);
      #1 bus.START = 1'b0;
      wait_to(t0 + 41);
      check("acc decode before reset",
            int'({bus.ld_sum, bus.sel_sum, bus.ld_k, bus.sel_k}), 15);
      #2 rst_n = 1'b0;
      flush_queues();
      #1 check("outputs at reset assertion", int'(outs()), 0);
      repeat (3) @(posedge clk);
      #1 check("outputs held in reset", int'(outs()), 0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1 check("outputs idle after mid-run reset", int'(outs()), 0);
      run_one(1'b0, 2);

`ifndef MMC_STEP_EN
      // START held high: two back-to-back runs with one IDLE cycle between
      repeat (2) @(posedge clk);
      #1 bus.START = 1'b1;
      t0 = cyc;
      push_run(t0, 1'b0);
      push_run(t0 + T_RUN, 1'b0);
      wait_to(t0 + T_RUN + 2);
      bus.START = 1'b0;
      wait_drain();
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   // Absolute time bound
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/matmul_controller.md
MATMUL_CONTROLLER -- requirements
Module: matmul_controller

Interface
REQ-001 Parameter HOLD_CYCLES, default 1: cycles from one NEW_OUTPUT pulse to the next in DUMP; legal range 1..255.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 START  input  1  begin one 3x3 multiply; sampled only in IDLE.
REQ-005 i_notEQ3, j_notEQ3, k_notEQ3  input  1 each  high while the index register value is not 3.
REQ-006 Done_Flag  input  1  high when the result-display counter has shown all 9 elements.
REQ-007 STEP  input  1  single-step display request; used only when MMC_STEP_EN is defined.
REQ-008 sel_i, sel_j, sel_k, sel_sum  output  1 each  0 = load zero, 1 = load incremented/accumulated value.
REQ-009 ld_i, ld_j, ld_k, ld_sum, ld_out  output  1 each  register load enables; ld_out writes SUM into matrix C.
REQ-010 Count_En, Show_DATA, NEW_OUTPUT  output  1 each  display counter control.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at end of run.

Function
REQ-013 The block SHALL be a Moore FSM; every output SHALL be decoded from current state only, except NEW_OUTPUT as stated in REQ-021.
REQ-014 States and asserted outputs: IDLE (none); INIT_I (ld_i, sel_i=0); INIT_J (ld_j, sel_j=0); CLR (ld_k, sel_k=0, ld_sum, sel_sum=0); RD (none; one cycle for synchronous ROM read); ACC (ld_sum, sel_sum=1, ld_k, sel_k=1); STORE (ld_out); INC_J (ld_j, sel_j=1); CHK_J (none); INC_I (ld_i, sel_i=1); CHK_I (none); SHOW (Show_DATA, Count_En); DUMP (Count_En); DONE (done).
REQ-015 Transitions: IDLE->INIT_I on START; INIT_I->INIT_J; INIT_J->CLR; CLR->RD; RD->ACC if k_notEQ3, otherwise STORE; ACC->RD; STORE->INC_J; INC_J->CHK_J; CHK_J->CLR if j_notEQ3, otherwise INC_I; INC_I->CHK_I; CHK_I->INIT_J if i_notEQ3, otherwise SHOW; SHOW->DUMP; DUMP->DONE when Done_Flag; DONE->IDLE.
REQ-016 Each result element SHALL take exactly 11 cycles and each row 36 cycles; with START high in IDLE at cycle 0, SHOW SHALL be occupied at cycle 110.
REQ-017 Exactly 9 ld_out pulses SHALL occur per run; the first SHALL be at cycle 11.
REQ-018 START SHALL be ignored outside IDLE; START held high SHALL trigger a new run from IDLE after DONE.
REQ-019 Done_Flag SHALL be ignored outside DUMP; if Done_Flag is high on DUMP entry, the next state SHALL be DONE.
REQ-020 Unused/illegal state encodings SHALL return to IDLE on the next edge.
REQ-021 In DUMP, NEW_OUTPUT SHALL pulse one cycle on DUMP entry and then every HOLD_CYCLES cycles, using an 8-bit hold counter cleared on DUMP entry.

Reset
REQ-022 RST low SHALL asynchronously force IDLE, clear the hold counter, and drive all outputs to 0, including mid-run.
REQ-023 After RST is released, no output SHALL assert until START is sampled high.

Configuration
REQ-024 Macro MMC_STEP_EN: when defined, the DUMP NEW_OUTPUT pulse SHALL be asserted only in a cycle where STEP is high, with one pulse per STEP rising edge, and HOLD_CYCLES unused; when undefined, STEP SHALL be ignored and REQ-021 applies.

Verification
REQ-025 Reset then START pulse at cycle 0, index flags modelled from a 2-bit counter -> 9 ld_out pulses at cycles 11, 22, 33, 47, 58, 69, 83, 94, 105; SHOW at 110.
REQ-026 START pulsed at cycle 50 of a run -> no state change; ld_out count stays 9.
REQ-027 HOLD_CYCLES=3, Done_Flag after 9 NEW_OUTPUTs -> NEW_OUTPUT pulses spaced 3 cycles apart; done pulses once; busy falls the cycle after done.
REQ-028 RST low during ACC of row 2 -> all outputs 0 immediately; restart yields the full REQ-025 sequence.
REQ-029 MMC_STEP_EN defined, STEP pulsed 9 times at irregular intervals -> exactly 9 NEW_OUTPUT pulses, each coincident with STEP.
REQ-030 START held high continuously -> back-to-back runs, IDLE occupied for one cycle between DONE and INIT_I.
